mptr_sched: RTL
===============

# mptr_sched

Round-robin access scheduler for the memory pointer registers that share the CPU address and data buses. Up to NREQ pointer registers raise requests. The block grants one at a time and drives that register's bus-enable strobes (read_abus, read_abusplus, read_dbus) along with the memory read/write strobes. It waits for the memory handshake, then reports completion to the requester. It guarantees exactly one rising edge of a pointer's read_abus per access, because the pointer applies its stored offset on that edge.

## Interface
- NREQ, 4: number of pointer registers served; minimum 2.
- WAIT_MAX, 15: maximum number of WAIT cycles before timeout; minimum 1.
- clk  in  1  system clock; everything is sampled on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-pointer access request, level-sensitive.
- req_op  in  2*NREQ  operation for requester i, in bits [2i+1:2i]:
  - 00: memory read at ptr.
  - 01: memory read at ptr+1.
  - 10: memory write at ptr.
  - 11: pointer value onto dbus only, no memory access.
- mem_ready  in  1  memory access complete; sampled only in WAIT.
- read_abus  out  NREQ  one-hot; put pointer i on abus.
- read_abusplus  out  NREQ  one-hot; put pointer i+1 on abus.
- read_dbus  out  NREQ  one-hot; put pointer i on dbus.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- done  out  NREQ  one-cycle pulse to the serviced requester.
- err  out  1  one-cycle pulse, coincident with done, when an access timed out.
- busy  out  1  high in every state except IDLE.

## Operation
- State machine: IDLE, ADDR, WAIT, DONE. Registered state, not one-hot-encoded outputs.
- All outputs are registered or decoded from registered state and the latched grant; no combinational path from req to any output.
- IDLE:
  - If req is nonzero, search for the winner starting at index rr, incrementing modulo NREQ.
  - Latch the winner index g and its req_op into op, clear wait_cnt, go to ADDR.
- ADDR (one cycle), drives the selected strobe only:
  - op 00 raises read_abus[g].
  - op 01 raises read_abusplus[g].
  - op 10 raises read_abus[g].
  - op 11 raises read_dbus[g].
  - Next state is DONE for op 11, otherwise WAIT.
- WAIT:
  - The same select strobe is held high, continuously from ADDR.
  - mem_rd is high for op 00/01; mem_wr is high for op 10.
  - If mem_ready is high, go to DONE.
  - Else if wait_cnt == WAIT_MAX-1, go to DONE with the timeout flag set.
  - Else increment wait_cnt.
- DONE (one cycle):
  - All select and memory strobes are low.
  - done[g]=1, and err=1 if the timeout flag is set.
  - rr becomes (g+1) mod NREQ; go to IDLE.
- Exactly one select strobe is high in ADDR/WAIT. mem_rd and mem_wr are never high together.
- A granted access runs to completion even if req[g] drops. A req dropped before grant is never serviced.
- req[g] still high in the IDLE cycle after DONE counts as a new request, but its priority is now lowest.
- req_op changes after the grant are ignored.
- wait_cnt width is clog2(WAIT_MAX+1); no wrap is possible.

## Timing
- Reset (reset=0, asynchronous):
  - State goes to IDLE, rr=0, wait_cnt=0, flags cleared.
  - All outputs are 0 immediately, including mid-access; no done pulse is issued for the aborted access.
- Minimum latency from req sampled in IDLE at edge 0:
  - ADDR during cycle 1.
  - WAIT during cycle 2.
  - With mem_ready=1 in cycle 2, DONE is during cycle 3 and IDLE during cycle 4.
- Op 11: ADDR in cycle 1, DONE in cycle 2.
- Timeout: exactly WAIT_MAX WAIT cycles, then DONE with err=1.
- Back-to-back accesses: minimum issue interval of 4 cycles for memory ops and 3 for op 11, because of the IDLE cycle.
- The select strobe has one rising edge (entering ADDR) and one falling edge (entering DONE) per access.

## Test plan
- Single read, op 00, requester 2, NREQ=4, mem_ready high in the first WAIT cycle:
  - read_abus = 0100 for 2 cycles, mem_rd high 1 cycle.
  - done = 0100 in cycle 3; busy low from cycle 4.
- Round robin, req = 1111 held continuously with op 11:
  - Grants in the order 0,1,2,3,0.
  - done pulses every 3 cycles; no requester is granted twice before all others.
- Write with 3 wait states, requester 1:
  - mem_wr high for 4 cycles, read_abus[1] high for 5 cycles with a single rising edge.
  - done = 0010, err = 0.
- Timeout with WAIT_MAX=15 and mem_ready held low:
  - mem_rd high for 15 cycles, then done and err pulse together.
  - rr advances.
- Reset mid-WAIT, asserting reset=0 during the second WAIT cycle:
  - All outputs are 0 within the same cycle; no done pulse.
  - After release, req = 0001 is serviced from IDLE with rr=0.
- Drop and ignore:
  - req[3] deasserted after its grant: the access still completes and done[3] pulses.
  - mem_ready pulsed during IDLE/ADDR has no effect.

Source files
------------

// File: rtl/mptr_sched.sv
// mptr_sched: round-robin scheduler for the memory pointer registers that
// share the CPU address and data buses. One requester is granted at a time.
// The scheduler drives that pointer's bus-enable strobe and the memory
// strobes, waits for the memory handshake or a timeout, and then pulses done
// back to the requester.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   req            per-pointer request, level-sensitive
//   req_op         2-bit op per requester at [2i+1:2i]
//                  (00 rd ptr, 01 rd ptr+1, 10 wr ptr, 11 ptr->dbus only)
//   mem_ready      memory handshake, sampled only in WAIT
//   read_abus      one-hot, pointer i onto abus
//   read_abusplus  one-hot, pointer i+1 onto abus
//   read_dbus      one-hot, pointer i onto dbus
//   mem_rd/mem_wr  memory strobes
//   done           one-cycle completion pulse to the served requester
//   err            one-cycle pulse with done when the access timed out
//   busy           high in every state except IDLE
//
// State | meaning
// IDLE  | no access; arbitrate among pending requests starting at rr
// ADDR  | first cycle of an access; the select strobe rises here
// WAIT  | select strobe held, memory strobe high, waiting for mem_ready
// DONE  | strobes low, done/err pulse, rr moves past the served requester
module mptr_sched #(
  parameter int NREQ     = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_op,
  input  logic              mem_ready,
  output logic [NREQ-1:0]   read_abus,
  output logic [NREQ-1:0]   read_abusplus,
  output logic [NREQ-1:0]   read_dbus,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            tmo_q, tmo_d;

  // Round-robin search: first requester at or after rr, wrapping.
  logic            arb_found;
  logic [GW-1:0]   arb_win;
  logic [1:0]      arb_op;
  logic [GW-1:0]   arb_g;
  int              arb_idx;

  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_op    = 2'b00;
    arb_g     = '0;
    arb_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = (int'(rr_q) + k) % NREQ;
      arb_g   = GW'(arb_idx);
      if (!arb_found && req[arb_g]) begin
        arb_found = 1'b1;
        arb_win   = arb_g;
        arb_op    = req_op[{arb_g, 1'b0} +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      g_q        <= '0;
      rr_q       <= '0;
      op_q       <= 2'b00;
      wait_cnt_q <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      rr_q       <= rr_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_d       = rr_q;
    op_d       = op_q;
    wait_cnt_d = wait_cnt_q;
    tmo_d      = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          g_d        = arb_win;
          op_d       = arb_op;
          wait_cnt_d = '0;
          tmo_d      = 1'b0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        state_d = (op_q == 2'b11) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_d = ST_DONE;
        end else if (wait_cnt_q == CW'(WAIT_MAX - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        rr_d    = (g_q == GW'(NREQ - 1)) ? '0 : g_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode only registered state and the latched grant/op, so reset
  // clears them immediately and req cannot reach them combinationally.
  logic [NREQ-1:0] g_oh;
  logic            sel_active;

  always_comb begin
    g_oh          = {{(NREQ-1){1'b0}}, 1'b1} << g_q;
    sel_active    = (state_q == ST_ADDR) || (state_q == ST_WAIT);
    read_abus     = '0;
    read_abusplus = '0;
    read_dbus     = '0;
    if (sel_active) begin
      case (op_q)
        2'b01:   read_abusplus = g_oh;
        2'b11:   read_dbus     = g_oh;
        default: read_abus     = g_oh;
      endcase
    end
    mem_rd = (state_q == ST_WAIT) && !op_q[1];
    mem_wr = (state_q == ST_WAIT) && (op_q == 2'b10);
    done   = (state_q == ST_DONE) ? g_oh : '0;
    err    = (state_q == ST_DONE) && tmo_q;
    busy   = (state_q != ST_IDLE);
  end

endmodule
